d16_wb_arbiter: RTL and testbench
=================================

Name: d16_wb_arbiter

Overview:
- Two-master, one-slave bus arbiter for the d16 16-bit memory bus.
- Master 0 is the d16 CPU; master 1 is the loader/debug port that writes program RAM while the CPU runs or is held.
- Round-robin grant; a grant is held until the slave acks or the master drops cyc.
- Optional watchdog terminates stuck cycles.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 15, cycles without ack before forced termination (used only with the optional feature; ≥1).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_addr / i_m1_addr  in  AW  master address.
- i_m0_dat / i_m1_dat  in  DW  master write data.
- i_m0_we / i_m1_we  in  1  write enable.
- i_m0_cyc / i_m1_cyc  in  1  cycle request; held until ack.
- o_m0_ack / o_m1_ack  out  1  transfer done, one cycle.
- o_m0_dat / o_m1_dat  out  DW  read data (slave data, gated to zero when the master is not granted).
- o_m0_err / o_m1_err  out  1  timeout termination (feature only; otherwise tied 0).
- o_s_addr  out  AW  slave address.
- o_s_dat  out  DW  slave write data.
- o_s_we  out  1  slave write enable.
- o_s_cyc  out  1  slave cycle.
- i_s_ack  in  1  slave ack.
- i_s_dat  in  DW  slave read data.
- o_gnt  out  2  one-hot registered grant: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- States: IDLE, GNT0, GNT1. o_gnt decodes the state.
- Reset: state IDLE, last-served pointer = m1 (so the CPU wins the first tie). Outputs on the cycle after the reset edge: o_s_cyc 0, o_s_we 0, all acks/errs 0, o_gnt 00.
- Reset mid-transfer: abandon the transfer, no ack issued, return to IDLE.
- IDLE:
  - Only m0 requesting -> GNT0.
  - Only m1 requesting -> GNT1.
  - Both requesting -> grant the master not last served.
  - Grant takes effect the next cycle: one cycle of latency from cyc to o_s_cyc.
- GNTx:
  - o_s_addr/dat/we come combinationally from master x.
  - o_s_cyc = i_mx_cyc.
  - o_mx_ack = i_s_ack, same cycle.
  - o_mx_dat = i_s_dat.
  - Non-granted master: ack 0, dat 0.
  - o_s_we is forced 0 when o_s_cyc is 0.
- On the ack cycle in GNTx: set last = x. Next state is GNT(other) if the other master's cyc is high, else IDLE. Back-to-back alternation therefore has zero idle cycles.
- A master re-requesting immediately after its ack re-enters through IDLE: one dead cycle.
- Abort: if i_mx_cyc drops while in GNTx without ack -> IDLE next cycle; last is not updated; o_s_cyc drops the same cycle.
- Ack while IDLE, or ack arriving after an abort: ignored, not routed to any master.
- Fairness: with both masters continuously requesting, grants strictly alternate; worst-case wait is one full slave transfer.
- Slave ack latency is arbitrary (0-wait slave acks in the first granted cycle).

Optional Feature:
- Macro: D16_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on grant entry and increments each granted cycle without ack.
  - When it reaches TIMEOUT: pulse o_mx_err (not ack) for one cycle, drop o_s_cyc that cycle, set last = x, re-arbitrate as on ack.
  - A slave ack on the terminal cycle takes precedence: ack is issued, err is not.
- Without the macro: no counter, err outputs tied 0, a grant is held indefinitely.

Decomposition:
- Shared package d16_bus_pkg:
  - state encoding localparams (ST_IDLE, ST_GNT0, ST_GNT1);
  - grant one-hot constants;
  - default AW/DW.
- Sub-module d16_arb_timer (the timeout counter with clear/enable/expired), instantiated only under D16_ARB_TIMEOUT_EN.
- Muxing and the FSM stay in the top module.

Test Plan:
- Reset, then m0 cyc=1 addr=0x0010 read, slave acks after 2 waits with dat=0xBEEF -> o_gnt=01 one cycle after request, o_m0_ack pulse with o_m0_dat=0xBEEF, o_m1_ack stays 0.
- m0 and m1 requesting simultaneously from IDLE after reset, 0-wait slave -> grant order m0, m1, m0, m1 with no IDLE between alternating transfers.
- m1 write addr=0x0100 dat=0x1234 while m0 idle -> o_s_we=1, o_s_addr=0x0100, o_s_dat=0x1234 during GNT1; ack routed only to m1.
- m0 drops cyc mid-transfer, slave acks one cycle later -> state IDLE, neither master acked, last pointer unchanged (next tie grants m0 again).
- i_reset asserted during GNT1 with the slave stalled -> next cycle o_s_cyc=0, o_gnt=00, no ack/err pulses.
- With D16_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks m0 -> o_m0_err pulse on the 4th granted cycle; pending m1 is granted the next cycle. Without the macro, the same stimulus holds GNT0 indefinitely.

Source files
------------

// File: rtl/d16_bus_pkg.sv
// rtl/d16_bus_pkg.sv - shared d16 bus widths, arbiter state encoding and grant constants
package d16_bus_pkg;

    localparam int D16_AW = 16;
    localparam int D16_DW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_GNT0 = ST_GNT0,
        S_GNT1 = ST_GNT1
    } arb_state_e;

    function automatic logic [1:0] gnt_of(input arb_state_e s);
        case (s)
            S_GNT0:  return GNT_M0;
            S_GNT1:  return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/d16_arb_timer.sv
// rtl/d16_arb_timer.sv - grant watchdog counter, built only with D16_ARB_TIMEOUT_EN
`ifdef D16_ARB_TIMEOUT_EN
module d16_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is seen on the TIMEOUT-th granted cycle, so compare against TIMEOUT-1.
    assign o_expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/d16_wb_arbiter.sv
// rtl/d16_wb_arbiter.sv - two-master round-robin d16 bus arbiter; optional watchdog via D16_ARB_TIMEOUT_EN
module d16_wb_arbiter
    import d16_bus_pkg::*;
#(
    parameter int AW      = D16_AW,
    parameter int DW      = D16_DW,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic          o_m0_ack,
    output logic [DW-1:0] o_m0_dat,
    output logic          o_m0_err,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic          o_m1_ack,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m1_err,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_dat,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic          i_s_ack,
    input  logic [DW-1:0] i_s_dat,
    output logic [1:0]    o_gnt
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;     // 0 = m0 last served, 1 = m1
    logic       sel0, sel1, cyc_x, ack_x, term_x, done_x;

    assign sel0   = (state_q == S_GNT0);
    assign sel1   = (state_q == S_GNT1);
    assign cyc_x  = (sel0 & i_m0_cyc) | (sel1 & i_m1_cyc);
    assign ack_x  = cyc_x & i_s_ack;
    assign done_x = ack_x | term_x;

`ifdef D16_ARB_TIMEOUT_EN
    logic expired;

    d16_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     ((state_q == S_IDLE) || (state_d != state_q)),
        .i_en      (cyc_x & ~i_s_ack),
        .o_expired (expired)
    );

    // A slave ack on the terminal cycle wins over the watchdog.
    assign term_x = cyc_x & expired & ~i_s_ack;
`else
    logic unused_timeout;
    assign unused_timeout = ^{1'b0, TIMEOUT[0]};
    assign term_x         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = S_GNT0;
                end else if (i_m1_cyc) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0: begin
                if (done_x) begin
                    last_d  = 1'b0;
                    state_d = i_m1_cyc ? S_GNT1 : S_IDLE;
                end else if (!i_m0_cyc) begin
                    state_d = S_IDLE;
                end
            end
            S_GNT1: begin
                if (done_x) begin
                    last_d  = 1'b1;
                    state_d = i_m0_cyc ? S_GNT0 : S_IDLE;
                end else if (!i_m1_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign o_s_cyc  = cyc_x & ~term_x;
    assign o_s_addr = sel1 ? i_m1_addr : (sel0 ? i_m0_addr : '0);
    assign o_s_dat  = sel1 ? i_m1_dat  : (sel0 ? i_m0_dat  : '0);
    assign o_s_we   = o_s_cyc & (sel1 ? i_m1_we : i_m0_we);

    // A transfer caught by reset is abandoned, so nothing is reported back.
    assign o_m0_ack = sel0 & ack_x  & ~i_reset;
    assign o_m1_ack = sel1 & ack_x  & ~i_reset;
    assign o_m0_err = sel0 & term_x & ~i_reset;
    assign o_m1_err = sel1 & term_x & ~i_reset;
    assign o_m0_dat = sel0 ? i_s_dat : '0;
    assign o_m1_dat = sel1 ? i_s_dat : '0;
    assign o_gnt    = gnt_of(state_q);

endmodule

// File: tb/tb_d16_wb_arbiter.sv
// tb/tb_d16_wb_arbiter.sv - scoreboard bench for d16_wb_arbiter, directed plus random traffic
module tb_d16_wb_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int TIMEOUT = 4;
`ifdef D16_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]    gnt;
        logic          s_cyc;
        logic          s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_dat;
        logic [1:0]    ack;
        logic [1:0]    err;
        logic [DW-1:0] dat0;
        logic [DW-1:0] dat1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    m_cyc, m_we;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_dat  [2];
    logic          s_ack;
    logic [DW-1:0] s_rdat;

    logic          m0_ack, m1_ack, m0_err, m1_err, s_we, s_cyc;
    logic [DW-1:0] m0_rdat, m1_rdat, s_wdat;
    logic [AW-1:0] s_addr;
    logic [1:0]    gnt;

    exp_t q[$];
    exp_t cur;
    int   owner, last, held;
    int   checks, errors;

    always #5 clk = ~clk;

    d16_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_m0_addr (m_addr[0]),
        .i_m0_dat  (m_dat[0]),
        .i_m0_we   (m_we[0]),
        .i_m0_cyc  (m_cyc[0]),
        .o_m0_ack  (m0_ack),
        .o_m0_dat  (m0_rdat),
        .o_m0_err  (m0_err),
        .i_m1_addr (m_addr[1]),
        .i_m1_dat  (m_dat[1]),
        .i_m1_we   (m_we[1]),
        .i_m1_cyc  (m_cyc[1]),
        .o_m1_ack  (m1_ack),
        .o_m1_dat  (m1_rdat),
        .o_m1_err  (m1_err),
        .o_s_addr  (s_addr),
        .o_s_dat   (s_wdat),
        .o_s_we    (s_we),
        .o_s_cyc   (s_cyc),
        .i_s_ack   (s_ack),
        .i_s_dat   (s_rdat),
        .o_gnt     (gnt)
    );

    // Reference: owner is whoever holds the bus (-1 none), held counts granted cycles so far.
    function automatic exp_t model_out();
        exp_t e;
        bit   timed_out;
        e = '0;
        if (owner >= 0) begin
            e.gnt = (owner == 0) ? 2'b01 : 2'b10;
            if (owner == 0) e.dat0 = s_rdat;
            else            e.dat1 = s_rdat;
            if (m_cyc[owner]) begin
                timed_out = TO_EN && (held == TIMEOUT - 1) && !s_ack;
                if (!timed_out) begin
                    e.s_cyc  = 1'b1;
                    e.s_we   = m_we[owner];
                    e.s_addr = m_addr[owner];
                    e.s_dat  = m_dat[owner];
                end
                e.ack[owner] = s_ack && !rst;
                e.err[owner] = timed_out && !rst;
            end
        end
        return e;
    endfunction

    task automatic update_model();
        bit done;
        done = (owner >= 0) && m_cyc[owner] &&
               (s_ack || (TO_EN && held == TIMEOUT - 1));
        if (rst) begin
            owner = -1;
            last  = 1;
        end else if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
            held = 0;
        end else if (done) begin
            last  = owner;
            owner = m_cyc[1 - owner] ? 1 - owner : -1;
            held  = 0;
        end else if (!m_cyc[owner]) begin
            owner = -1;
        end else begin
            held++;
        end
    endtask

    task automatic step();
        cur = model_out();
        q.push_back(cur);
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt",   32'(gnt),    32'(e.gnt));
            chk("s_cyc", 32'(s_cyc),  32'(e.s_cyc));
            chk("s_we",  32'(s_we),   32'(e.s_we));
            chk("acks",  32'({m1_ack, m0_ack}), 32'(e.ack));
            chk("errs",  32'({m1_err, m0_err}), 32'(e.err));
            chk("m0_dat", 32'(m0_rdat), 32'(e.dat0));
            chk("m1_dat", 32'(m1_rdat), 32'(e.dat1));
            if (e.s_cyc) begin
                chk("s_addr", 32'(s_addr), 32'(e.s_addr));
                chk("s_dat",  32'(s_wdat), 32'(e.s_dat));
            end
        end
    end

    task automatic drive(input logic c0, input logic c1, input logic ack, input logic [DW-1:0] d);
        m_cyc[0] = c0;
        m_cyc[1] = c1;
        s_ack    = ack;
        s_rdat   = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        owner  = -1;
        last   = 1;
        held   = 0;
        rst    = 1'b1;
        m_cyc  = 2'b00;
        m_we   = 2'b00;
        m_addr[0] = '0; m_addr[1] = '0;
        m_dat[0]  = '0; m_dat[1]  = '0;
        s_ack  = 1'b0;
        s_rdat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();                                     // post-reset idle outputs

        // m0 read of 0x0010, slave acks after two wait cycles with 0xBEEF
        m_addr[0] = 16'h0010; m_we[0] = 1'b0;
        drive(1, 0, 0, 16'h0000); step();
        drive(1, 0, 0, 16'h0000); step(); step();
        drive(1, 0, 1, 16'hBEEF); step();
        drive(0, 0, 0, 16'h0000); step();

        // both masters hammering a zero-wait slave: strict alternation
        m_addr[1] = 16'h0200;
        drive(1, 1, 1, 16'h5A5A);
        repeat (7) step();
        drive(0, 0, 0, 16'h0000); step(); step();

        // m1 write while m0 idle
        m_addr[1] = 16'h0100; m_dat[1] = 16'h1234; m_we[1] = 1'b1;
        drive(0, 1, 0, 16'h0000); step(); step();
        drive(0, 1, 1, 16'h0000); step();
        drive(0, 0, 0, 16'h0000); step();
        m_we[1] = 1'b0;

        // m0 aborts, late ack ignored, then a tie goes to m0 again
        drive(1, 0, 0, 16'h0000); step(); step();
        drive(0, 0, 0, 16'h0000); step();
        drive(0, 0, 1, 16'h7777); step();
        drive(1, 1, 0, 16'h0000); step(); step();
        drive(1, 1, 1, 16'h0001); step(); step();
        drive(0, 0, 0, 16'h0000); step();

        // reset while m1 is granted and stalled
        drive(0, 1, 0, 16'h0000); step(); step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        drive(0, 0, 0, 16'h0000); step();

        // slave never acks m0 while m1 waits: watchdog fires or grant is held
        drive(1, 1, 0, 16'h0000);
        repeat (8) step();
        drive(0, 0, 0, 16'h0000); step(); step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s_ack  = ($urandom_range(99) < 35);
            s_rdat = DW'($urandom);
            rst    = ($urandom_range(199) == 0);
            for (int x = 0; x < 2; x++) begin
                if (m_cyc[x] && (cur.ack[x] || cur.err[x])) begin
                    m_cyc[x] = $urandom_range(1);
                    m_addr[x] = AW'($urandom);
                    m_dat[x]  = DW'($urandom);
                    m_we[x]   = $urandom_range(1);
                end else if (m_cyc[x]) begin
                    if ($urandom_range(99) < 4) m_cyc[x] = 1'b0;
                end else if ($urandom_range(99) < 25) begin
                    m_cyc[x]  = 1'b1;
                    m_addr[x] = AW'($urandom);
                    m_dat[x]  = DW'($urandom);
                    m_we[x]   = $urandom_range(1);
                end
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
